alu_req_sequencer: RTL and testbench
====================================

// Module: alu_req_sequencer
// PURPOSE
//  Shares one sign-magnitude ALU (ADD/SUB/MUL/DIV, 3-bit operands, 5-bit result, SF/ZF/DZF flags)
//  among N_REQ requesters. Round-robin arbitration, operand capture, and one ALU operation at a time.
//  Waits ALU_LAT cycles, then returns the registered result and flags on a valid/ready response port.
//  Sits between the requesting control blocks and the combinational ALU datapath.
// PARAMETERS
//  N_REQ    2  number of requesters (2..8); IDW = $clog2(N_REQ)
//  ALU_LAT  1  cycles from alu_* drive to sampling alu_r/flags (>=1)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  req_valid  in   N_REQ    per-requester request
//  req_ready  out  N_REQ    one-hot accept; handshake = valid & ready
//  req_op     in   2*N_REQ  opcode per requester, slice i = [2i+1:2i]
//  req_a      in   3*N_REQ  operand A per requester, sign-magnitude {sign,mag[1:0]}
//  req_b      in   3*N_REQ  operand B per requester, same encoding
//  rsp_valid  out  1        response available
//  rsp_ready  in   1        response consumer accept
//  rsp_id     out  IDW      index of the requester that issued the op
//  rsp_r      out  5        result, sign-magnitude {sign,mag[3:0]}
//  rsp_sf     out  1        sign flag; rsp_zf  out 1 zero flag; rsp_dzf out 1 divide-by-zero flag
//  alu_op     out  2        opcode to shared ALU
//  alu_a      out  3        operand A to shared ALU; alu_b out 3 operand B to shared ALU
//  alu_r      in   5        ALU result; alu_sf/alu_zf/alu_dzf in 1 each, ALU flags
// BEHAVIOUR
//  Opcodes: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
//  FSM states: IDLE, EXEC, RESP. Reset -> IDLE.
//  Reset values: every output is 0, rr pointer = N_REQ-1 (req 0 wins first), wait counter = 0.
//  IDLE: winner g = first asserted req_valid searching from ptr+1 mod N_REQ.
//   - req_ready[g]=1 combinationally, same cycle; all other req_ready bits are 0.
//   - On the handshake: capture op/a/b/id into registers, set ptr=g, set cnt=ALU_LAT-1, go to EXEC.
//   - No valid requests -> stay in IDLE.
//  EXEC: alu_op/a/b are driven from the captured registers and held stable.
//   - cnt!=0 -> decrement.
//   - cnt==0 -> register alu_r/sf/zf/dzf into rsp_*, go to RESP.
//  RESP: rsp_valid=1; rsp_* and rsp_id are held stable until rsp_ready.
//   - On rsp_ready, go to IDLE; rsp_valid deasserts next cycle.
//  Outside IDLE, req_ready is all-0. A requester may drop valid before being granted; nothing happens.
//  Latency: handshake in cycle t -> rsp_valid in cycle t+ALU_LAT+1. Minimum issue interval is ALU_LAT+2.
//  Results pass through unmodified; negative zero (10000) is not canonicalised.
//  alu_* keep their last captured values in IDLE/RESP (they do not return to 0).
//  Reset asserted mid-EXEC/RESP: the op is discarded, no response is issued, and all outputs go to 0 at once.
//  Simultaneous rsp_ready and new req_valid in RESP: only the response completes; arbitration happens next cycle in IDLE.
// CONFIGURATION
//  ALU_SEQ_DZ_BYPASS_EN defined:
//   - An accepted DIV with B[1:0]==00 skips EXEC; the ALU is not re-driven (alu_* keep their old values).
//   - The next state is RESP with rsp_r=0, sf=0, zf=1, dzf=1; latency is t+1.
//  Not defined: all ops go through EXEC; flags come from the ALU.
// STRUCTURE
//  alu_pkg: opcode localparams, SM_IN_W=3, SM_OUT_W=5, FSM state encoding.
//  Sub-module alu_rr_arbiter: combinational round-robin pick (req_valid, ptr -> one-hot grant, index).
//  Everything else (FSM, capture registers, counter, response registers) lives in this module.
// TESTING (the bench models the ALU with the existing mul behaviour plus add/sub/div)
//  1 req0 MUL A=011 B=110, ALU_LAT=1 -> rsp at t+2: id=0, r=10110, sf=1, zf=0, dzf=0.
//  2 req0,req1 valid continuously for 8 ops -> grants alternate 0,1,0,1...; first grant goes to 0.
//  3 rsp_ready held low 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout; accept resumes after ready.
//  4 DIV A=010 B=100 -> dzf=1. With the macro: rsp at t+1, r=00000, zf=1, alu_* unchanged from the prior op.
//  5 rst_n low in the 2nd EXEC cycle (ALU_LAT=3) -> all outputs 0 immediately, no rsp after release, req0 wins first.
//  6 ADD A=101 B=001 -> r magnitude 0000, zf=1; ALU_LAT=4 -> rsp exactly at t+5.

Source files
------------

// File: rtl/alu_req_sequencer_pkg.sv
// Shared definitions for the ALU request sequencer: operand/result widths,
// opcode values, FSM state encoding and the divide-by-zero detector used by
// the optional ALU_SEQ_DZ_BYPASS_EN fast path.
package alu_req_sequencer_pkg;

   localparam int SM_IN_W  = 3;   // {sign, mag[1:0]}
   localparam int SM_OUT_W = 5;   // {sign, mag[3:0]}

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } seq_state_e;

   // A DIV whose divisor magnitude is zero; the sign bit of B is irrelevant.
   function automatic logic is_div_by_zero(input logic [1:0]         op,
                                           input logic [SM_IN_W-1:0] b);
      return (op == OP_DIV) && (b[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/alu_req_sequencer_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request found when
// searching upward from (ptr+1) mod N_REQ wins. Produces a one-hot grant,
// the winner index and an "anyone requesting" flag.
module alu_rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int IDW   = 1
) (
   input  logic [N_REQ-1:0] i_req_valid,
   input  logic [IDW-1:0]   i_ptr,
   output logic [N_REQ-1:0] o_grant,
   output logic [IDW-1:0]   o_gnt_idx,
   output logic             o_any
);

   // Rotating priority search starting just after the last winner
   always_comb begin
      int j;
      o_grant   = '0;
      o_gnt_idx = '0;
      o_any     = 1'b0;
      j         = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         j = (int'(i_ptr) + k) % N_REQ;
         if (!o_any && i_req_valid[j]) begin
            o_grant[j] = 1'b1;
            o_gnt_idx  = IDW'(j);
            o_any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_req_sequencer.sv
// Shares one combinational sign-magnitude ALU among N_REQ requesters.
// A round-robin winner is accepted in IDLE, its operands are held on alu_*
// for ALU_LAT cycles (EXEC), then the ALU outputs are registered and offered
// on the rsp_* valid/ready port (RESP).
// Optional feature macro: ALU_SEQ_DZ_BYPASS_EN -- a DIV with a zero divisor
// magnitude skips EXEC and answers next cycle with r=0, sf=0, zf=1, dzf=1,
// leaving alu_* untouched.
module alu_req_sequencer
   import alu_req_sequencer_pkg::*;
#(
   parameter  int N_REQ   = 2,
   parameter  int ALU_LAT = 1,
   localparam int IDW     = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [2*N_REQ-1:0]    req_op,
   input  logic [3*N_REQ-1:0]    req_a,
   input  logic [3*N_REQ-1:0]    req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [SM_OUT_W-1:0]   rsp_r,
   output logic                  rsp_sf,
   output logic                  rsp_zf,
   output logic                  rsp_dzf,
   output logic [1:0]            alu_op,
   output logic [SM_IN_W-1:0]    alu_a,
   output logic [SM_IN_W-1:0]    alu_b,
   input  logic [SM_OUT_W-1:0]   alu_r,
   input  logic                  alu_sf,
   input  logic                  alu_zf,
   input  logic                  alu_dzf
);

   localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   seq_state_e            r_state;
   logic [IDW-1:0]        r_ptr;
   logic [CW-1:0]         r_cnt;
   logic [IDW-1:0]        r_id;
   logic [1:0]            r_op;
   logic [SM_IN_W-1:0]    r_a;
   logic [SM_IN_W-1:0]    r_b;
   logic                  r_rsp_valid;
   logic [IDW-1:0]        r_rsp_id;
   logic [SM_OUT_W-1:0]   r_rsp_r;
   logic                  r_rsp_sf;
   logic                  r_rsp_zf;
   logic                  r_rsp_dzf;

   logic [N_REQ-1:0]      w_grant;
   logic [IDW-1:0]        w_gnt_idx;
   logic                  w_any;
   logic [1:0]            w_sel_op;
   logic [SM_IN_W-1:0]    w_sel_a;
   logic [SM_IN_W-1:0]    w_sel_b;

   alu_rr_arbiter #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_arb (
      .i_req_valid (req_valid),
      .i_ptr       (r_ptr),
      .o_grant     (w_grant),
      .o_gnt_idx   (w_gnt_idx),
      .o_any       (w_any)
   );

   // Select the winning requester's opcode and operands
   always_comb begin
      w_sel_op = '0;
      w_sel_a  = '0;
      w_sel_b  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_op = req_op[2*i +: 2];
            w_sel_a  = req_a[3*i +: 3];
            w_sel_b  = req_b[3*i +: 3];
         end
      end
   end

   // Grants exist only in IDLE and are forced low while reset is asserted
   assign req_ready = ((r_state == ST_IDLE) && rst_n) ? w_grant : '0;

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_r     = r_rsp_r;
   assign rsp_sf    = r_rsp_sf;
   assign rsp_zf    = r_rsp_zf;
   assign rsp_dzf   = r_rsp_dzf;
   assign alu_op    = r_op;
   assign alu_a     = r_a;
   assign alu_b     = r_b;

   // Sequencer FSM: accept, hold operands for ALU_LAT cycles, respond
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ptr       <= IDW'(N_REQ - 1);
         r_cnt       <= '0;
         r_id        <= '0;
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_r     <= '0;
         r_rsp_sf    <= 1'b0;
         r_rsp_zf    <= 1'b0;
         r_rsp_dzf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Any valid request is granted and handshaken this cycle
               if (w_any) begin
                  r_ptr <= w_gnt_idx;
`ifdef ALU_SEQ_DZ_BYPASS_EN
                  if (is_div_by_zero(w_sel_op, w_sel_b)) begin
                     // Answer directly; the ALU keeps its previous operands
                     r_rsp_id    <= w_gnt_idx;
                     r_rsp_r     <= '0;
                     r_rsp_sf    <= 1'b0;
                     r_rsp_zf    <= 1'b1;
                     r_rsp_dzf   <= 1'b1;
                     r_rsp_valid <= 1'b1;
                     r_state     <= ST_RESP;
                  end else begin
                     r_id    <= w_gnt_idx;
                     r_op    <= w_sel_op;
                     r_a     <= w_sel_a;
                     r_b     <= w_sel_b;
                     r_cnt   <= CW'(ALU_LAT - 1);
                     r_state <= ST_EXEC;
                  end
`else
                  r_id    <= w_gnt_idx;
                  r_op    <= w_sel_op;
                  r_a     <= w_sel_a;
                  r_b     <= w_sel_b;
                  r_cnt   <= CW'(ALU_LAT - 1);
                  r_state <= ST_EXEC;
`endif
               end
            end
            ST_EXEC: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  // ALU outputs have settled; pass them through unmodified
                  r_rsp_id    <= r_id;
                  r_rsp_r     <= alu_r;
                  r_rsp_sf    <= alu_sf;
                  r_rsp_zf    <= alu_zf;
                  r_rsp_dzf   <= alu_dzf;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               // New requests wait for IDLE even if rsp_ready arrives now
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Self-checking bench for alu_req_sequencer. Three instances (ALU_LAT = 1, 3, 4)
// share stimulus; only the selected one sees requests and rsp_ready.
// Each instance is backed by a behavioural sign-magnitude ALU.
module tb_alu_req_sequencer;

   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst_n;
   logic [1:0] req_valid;
   logic       rsp_ready;
   logic [1:0] tb_op [2];
   logic [2:0] tb_a  [2];
   logic [2:0] tb_b  [2];
   logic [3:0] req_op;
   logic [5:0] req_a;
   logic [5:0] req_b;
   int         sel;

   logic [1:0] d_req_ready [NI];
   logic       d_rsp_valid [NI];
   logic       d_rsp_id    [NI];
   logic [4:0] d_rsp_r     [NI];
   logic       d_sf        [NI];
   logic       d_zf        [NI];
   logic       d_dzf       [NI];
   logic [1:0] d_alu_op    [NI];
   logic [2:0] d_alu_a     [NI];
   logic [2:0] d_alu_b     [NI];

   logic [1:0] o_req_ready;
   logic       o_rsp_valid;
   logic       o_rsp_id;
   logic [4:0] o_rsp_r;
   logic       o_sf, o_zf, o_dzf;
   logic [1:0] o_alu_op;
   logic [2:0] o_alu_a, o_alu_b;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int mptr     [NI];
   logic [7:0] last_alu [NI];
   logic [7:0] got;

   always #5 clk = ~clk;

   // Sign-magnitude ALU: returns {r[4:0], sf, zf, dzf}
   function automatic logic [7:0] alu_model(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
      int av, bv, rv;
      logic s, dz;
      logic [3:0] m;
      av = a[2] ? -int'({30'b0, a[1:0]}) : int'({30'b0, a[1:0]});
      bv = b[2] ? -int'({30'b0, b[1:0]}) : int'({30'b0, b[1:0]});
      dz = 1'b0;
      rv = 0;
      s  = 1'b0;
      case (op)
         2'b00: begin rv = av + bv; s = (rv < 0); end
         2'b01: begin rv = av - bv; s = (rv < 0); end
         2'b10: begin rv = av * bv; s = a[2] ^ b[2]; end
         default: begin
            if (b[1:0] == 2'b00) begin rv = 0; s = 1'b0; dz = 1'b1; end
            else begin rv = av / bv; s = a[2] ^ b[2]; end
         end
      endcase
      m = 4'((rv < 0) ? -rv : rv);
      return {s, m, s, (m == 4'd0), dz};
   endfunction

   function automatic int lat_of(input int s);
      return (s == 0) ? 1 : ((s == 1) ? 3 : 4);
   endfunction

   // Round-robin rule: first valid searching from last winner + 1
   function automatic int rr_pick(input logic [1:0] v, input int ptr);
      for (int k = 1; k <= 2; k++) begin
         int j;
         j = (ptr + k) % 2;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   assign req_op = {tb_op[1], tb_op[0]};
   assign req_a  = {tb_a[1], tb_a[0]};
   assign req_b  = {tb_b[1], tb_b[0]};

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      logic [7:0] w_alu;
      logic [1:0] w_req_valid;
      logic       w_rsp_ready;
      assign w_req_valid = (sel == gi) ? req_valid : 2'b00;
      assign w_rsp_ready = rsp_ready && (sel == gi);
      assign w_alu = alu_model(d_alu_op[gi], d_alu_a[gi], d_alu_b[gi]);
      alu_req_sequencer #(.N_REQ(2), .ALU_LAT((gi == 0) ? 1 : ((gi == 1) ? 3 : 4))) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .req_valid (w_req_valid),
         .req_ready (d_req_ready[gi]),
         .req_op    (req_op),
         .req_a     (req_a),
         .req_b     (req_b),
         .rsp_valid (d_rsp_valid[gi]),
         .rsp_ready (w_rsp_ready),
         .rsp_id    (d_rsp_id[gi]),
         .rsp_r     (d_rsp_r[gi]),
         .rsp_sf    (d_sf[gi]),
         .rsp_zf    (d_zf[gi]),
         .rsp_dzf   (d_dzf[gi]),
         .alu_op    (d_alu_op[gi]),
         .alu_a     (d_alu_a[gi]),
         .alu_b     (d_alu_b[gi]),
         .alu_r     (w_alu[7:3]),
         .alu_sf    (w_alu[2]),
         .alu_zf    (w_alu[1]),
         .alu_dzf   (w_alu[0])
      );
   end

   always_comb begin
      o_req_ready = d_req_ready[sel];
      o_rsp_valid = d_rsp_valid[sel];
      o_rsp_id    = d_rsp_id[sel];
      o_rsp_r     = d_rsp_r[sel];
      o_sf        = d_sf[sel];
      o_zf        = d_zf[sel];
      o_dzf       = d_dzf[sel];
      o_alu_op    = d_alu_op[sel];
      o_alu_a     = d_alu_a[sel];
      o_alu_b     = d_alu_b[sel];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < NI; i++) begin
         mptr[i]     = 1;
         last_alu[i] = 8'h00;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      reset_model();
   endtask

   task automatic randomize_ops();
      for (int i = 0; i < 2; i++) begin
         tb_op[i] = 2'($urandom); tb_a[i] = 3'($urandom); tb_b[i] = 3'($urandom);
      end
   endtask

   // Entered and left at a negedge. Waits for a grant, checks it, then the
   // response latency, contents and hold behaviour; rsp is accepted after hold cycles.
   task automatic run_op(input int hold, input bit keep, output logic [7:0] res);
      int g, lat, exp_lat;
      bit found, byp;
      logic [1:0] op;
      logic [2:0] a, b;
      logic [7:0] e;
      found = 1'b0;
      res   = 8'hxx;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (o_req_ready != 2'b00) begin found = 1'b1; break; end
         @(negedge clk);
      end
      check("grant_seen", 32'(found), 32'(1));
      if (!found) return;
      g = rr_pick(req_valid, mptr[sel]);
      check("grant_onehot", 32'(o_req_ready), 32'(1) << g);
      op = tb_op[g]; a = tb_a[g]; b = tb_b[g];
      mptr[sel] = g;
`ifdef ALU_SEQ_DZ_BYPASS_EN
      byp = (op == 2'b11) && (b[1:0] == 2'b00);
`else
      byp = 1'b0;
`endif
      if (byp) begin
         e = 8'b00000_011;
         exp_lat = 1;
      end else begin
         e = alu_model(op, a, b);
         exp_lat = lat_of(sel) + 1;
         last_alu[sel] = {op, a, b};
      end
      @(posedge clk); #1;
      if (keep) begin
         tb_op[g] = 2'($urandom); tb_a[g] = 3'($urandom); tb_b[g] = 3'($urandom);
      end else begin
         req_valid[g] = 1'b0;
      end
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         check("busy_no_grant", 32'(o_req_ready), 32'(0));
         if (o_rsp_valid) break;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("rsp_id", 32'(o_rsp_id), 32'(g));
      check("rsp_r_flags", 32'({o_rsp_r, o_sf, o_zf, o_dzf}), 32'(e));
      check("alu_operands", 32'({o_alu_op, o_alu_a, o_alu_b}), 32'(last_alu[sel]));
      res = {o_rsp_r, o_sf, o_zf, o_dzf};
      for (int d = 0; d < hold; d++) begin
         @(negedge clk);
         check("hold_valid", 32'(o_rsp_valid), 32'(1));
         check("hold_rsp", 32'({o_rsp_id, o_rsp_r, o_sf, o_zf, o_dzf}), 32'({g[0], e}));
         check("hold_no_grant", 32'(o_req_ready), 32'(0));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("rsp_drop", 32'(o_rsp_valid), 32'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0; sel = 0;
      for (int i = 0; i < 2; i++) begin tb_op[i] = '0; tb_a[i] = '0; tb_b[i] = '0; end
      reset_model();
      repeat (2) @(negedge clk);
      // Reset state, including no grant while reset holds
      req_valid = 2'b11; #1;
      for (int s = 0; s < NI; s++) begin
         sel = s; #1;
         check("reset_outputs", 32'({o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_r, o_sf, o_zf, o_dzf,
                                      o_alu_op, o_alu_a, o_alu_b}), 32'(0));
      end
      req_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;

      // 1: MUL +3 * -2 on the 1-cycle ALU
      sel = 0;
      tb_op[0] = 2'b10; tb_a[0] = 3'b011; tb_b[0] = 3'b110; req_valid = 2'b01;
      run_op(0, 1'b0, got);
      check("t1_result", 32'(got), 32'(8'b10110_100));

      // 2: two continuous requesters alternate, starting at requester 0
      do_reset();
      sel = 0;
      randomize_ops();
      req_valid = 2'b11;
      for (int i = 0; i < 8; i++) begin
         #1;
         check("t2_alternate", 32'(o_req_ready), (i % 2 == 0) ? 32'(1) : 32'(2));
         run_op(0, 1'b1, got);
      end
      req_valid = 2'b00;

      // 3: response back-pressure for 5 cycles, then accept resumes
      sel = 1;
      randomize_ops();
      req_valid = 2'b11;
      run_op(5, 1'b1, got);
      run_op(0, 1'b1, got);
      req_valid = 2'b00;

      // 4: a normal op, then DIV by zero magnitude
      sel = 0;
      tb_op[0] = 2'b00; tb_a[0] = 3'b001; tb_b[0] = 3'b010; req_valid = 2'b01;
      run_op(0, 1'b0, got);
      tb_op[1] = 2'b11; tb_a[1] = 3'b010; tb_b[1] = 3'b100; req_valid = 2'b10;
      run_op(0, 1'b0, got);
      check("t4_divzero", 32'(got), 32'(8'b00000_011));

      // 5: reset in the second EXEC cycle of a 3-cycle op
      do_reset();
      sel = 1;
      tb_op[0] = 2'b10; tb_a[0] = 3'b011; tb_b[0] = 3'b011; req_valid = 2'b01;
      #1;
      check("t5_grant", 32'(o_req_ready), 32'(1));
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(posedge clk); #1;
      rst_n = 1'b0;
      req_valid = 2'b11;
      #1;
      check("t5_outputs_zero", 32'({o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_r, o_sf, o_zf, o_dzf,
                                     o_alu_op, o_alu_a, o_alu_b}), 32'(0));
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      reset_model();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("t5_no_rsp", 32'(o_rsp_valid), 32'(0));
      end
      randomize_ops();
      req_valid = 2'b11; #1;
      check("t5_req0_first", 32'(o_req_ready), 32'(1));
      run_op(0, 1'b0, got);
      req_valid = 2'b00;

      // 6: ADD -1 + +1 on the 4-cycle ALU
      sel = 2;
      tb_op[0] = 2'b00; tb_a[0] = 3'b101; tb_b[0] = 3'b001; req_valid = 2'b01;
      run_op(0, 1'b0, got);
      check("t6_mag_zero", 32'(got[6:3]), 32'(0));
      check("t6_zf", 32'(got[1]), 32'(1));

      // Randomized traffic on every latency
      for (int s = 0; s < NI; s++) begin
         sel = s;
         for (int i = 0; i < 12; i++) begin
            randomize_ops();
            req_valid = 2'($urandom_range(1, 3));
            run_op(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
         end
         req_valid = 2'b00;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
